sipo_y_sched: RTL and testbench

//  Sequencer for the Y-operand serial-in/parallel-out ring buffer feeding the PE array.

---
 rtl/sipo_y_sched_if.sv | 31 +++
 rtl/sipo_y_sched.sv | 111 +++++++++++
 tb/tb_sipo_y_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_y_sched_if.sv
// Stream, load, shift and status signals shared by the Y-operand sequencer and its neighbours.
// The master side drives the control and upstream inputs; the slave side is the sequencer.
interface sipo_y_sched_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ITER_NUM   = 4
);
    localparam int RW = $clog2(ITER_NUM);

    logic                    start;
    logic                    abort;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*DATA_WIDTH-1:0] in_data;
    logic                    ld_v;
    logic [2*DATA_WIDTH-1:0] ld_data;
    logic                    pe_ready;
    logic                    shift_v;
    logic [RW-1:0]           round;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, in_valid, in_data, pe_ready,
        input  in_ready, ld_v, ld_data, shift_v, round, busy, done
    );

    modport slave (
        input  start, abort, in_valid, in_data, pe_ready,
        output in_ready, ld_v, ld_data, shift_v, round, busy, done
    );
endinterface

// File: rtl/sipo_y_sched.sv
// Sequencer for the Y-operand SIPO ring buffer: loads PE_NUM*REG_NUM words, then
// issues ITER_NUM bursts of REG_NUM ring shifts, each gated by PE-array readiness.
module sipo_y_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int PE_NUM     = 8,
    parameter int REG_NUM    = 32,
    parameter int ITER_NUM   = 4
) (
    input  logic          clk,
    input  logic          rst,
    sipo_y_sched_if.slave bus
);
    localparam int LCW = $clog2(PE_NUM * REG_NUM);
    localparam int SCW = $clog2(REG_NUM);
    localparam int RW  = $clog2(ITER_NUM);

    localparam logic [LCW-1:0] LOAD_LAST  = LCW'(PE_NUM * REG_NUM - 1);
    localparam logic [SCW-1:0] SHIFT_LAST = SCW'(REG_NUM - 1);
    localparam logic [RW-1:0]  ROUND_LAST = RW'(ITER_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [LCW-1:0]          r_loadCnt;
    logic [SCW-1:0]          r_shiftCnt;
    logic [RW-1:0]           r_round;
    logic                    r_ldV;
    logic [2*DATA_WIDTH-1:0] r_ldData;
    logic                    w_xfer;

    // Status strobes are pure decodes of the state register so they never glitch or gap.
    assign bus.in_ready = (r_state == S_LOAD);
    assign bus.shift_v  = (r_state == S_SHIFT);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.ld_v     = r_ldV;
    assign bus.ld_data  = r_ldData;
    assign bus.round    = r_round;

    assign w_xfer = bus.in_valid && (r_state == S_LOAD);

    // Abort takes priority over everything, so a word accepted in the abort cycle never reaches the SIPO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_loadCnt  <= '0;
            r_shiftCnt <= '0;
            r_round    <= '0;
            r_ldV      <= 1'b0;
            r_ldData   <= '0;
        end else begin
            r_ldV <= 1'b0;
            if (bus.abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state    <= S_LOAD;
                            r_loadCnt  <= '0;
                            r_shiftCnt <= '0;
                            r_round    <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (w_xfer) begin
                            r_ldV    <= 1'b1;
                            r_ldData <= bus.in_data;
                            if (r_loadCnt == LOAD_LAST) begin
                                r_loadCnt <= '0;
                                r_state   <= S_WAIT;
                            end else begin
                                r_loadCnt <= r_loadCnt + LCW'(1);
                            end
                        end
                    end
                    S_WAIT: begin
                        if (bus.pe_ready) begin
                            r_state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (r_shiftCnt == SHIFT_LAST) begin
                            r_shiftCnt <= '0;
                            if (r_round == ROUND_LAST) begin
                                r_state <= S_DONE;
                            end else begin
                                r_round <= r_round + RW'(1);
                                r_state <= S_WAIT;
                            end
                        end else begin
                            r_shiftCnt <= r_shiftCnt + SCW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sipo_y_sched.sv
// Bench for sipo_y_sched: directed scenarios plus random traffic, every cycle compared
// against a count-based reference model of the load/shift schedule.
module tb_sipo_y_sched;
    localparam int DW = 16;
    localparam int PE = 4;
    localparam int RG = 4;
    localparam int IT = 2;
    localparam int NW = PE * RG;
    localparam int NS = IT * RG;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sipo_y_sched_if #(.DATA_WIDTH(DW), .ITER_NUM(IT)) bus ();

    sipo_y_sched #(
        .DATA_WIDTH(DW),
        .PE_NUM    (PE),
        .REG_NUM   (RG),
        .ITER_NUM  (IT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stimulus values applied at the next rising edge.
    bit          dRst, dStart, dAbort, dValid, dPe;
    logic [31:0] dData;

    // Reference model: words accepted, shift cycles issued, cycles left in the current burst.
    int          mWords, mShifts, mBurst;
    bit          mActive, mDone, mLdV;
    logic [31:0] mLdData;

    int passCnt, totalCnt;
    int ldCnt, shCnt, doneCnt, runLen, burstBad;
    string scen;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", scen, name, obs, exp);
    endtask

    task automatic modelStep();
        bit xfer, waiting, wasDone;
        if (dRst) begin
            mWords = 0; mShifts = 0; mBurst = 0;
            mActive = 0; mDone = 0; mLdV = 0; mLdData = '0;
        end else if (dAbort) begin
            mActive = 0; mBurst = 0; mDone = 0; mLdV = 0;
        end else begin
            xfer    = mActive && (mWords < NW) && dValid;
            waiting = mActive && (mWords == NW) && (mBurst == 0) && !mDone && (mShifts < NS);
            wasDone = mDone;
            mLdV    = xfer;
            if (xfer) begin
                mLdData = dData;
                mWords++;
            end
            mDone = 0;
            if (mBurst > 0) begin
                mBurst--;
                mShifts++;
                if (mBurst == 0 && mShifts == NS) mDone = 1;
            end else if (waiting && dPe) begin
                mBurst = RG;
            end
            if (wasDone) begin
                mActive = 0;
            end else if (!mActive && dStart) begin
                mActive = 1; mWords = 0; mShifts = 0;
            end
        end
    endtask

    task automatic applyStimulus();
        int eRound;
        rst          = dRst;
        bus.start    = dStart;
        bus.abort    = dAbort;
        bus.in_valid = dValid;
        bus.in_data  = dData;
        bus.pe_ready = dPe;
        @(posedge clk);
        modelStep();
        #1;
        eRound = mShifts / RG;
        if (eRound > IT - 1) eRound = IT - 1;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(mActive && mWords < NW));
        checkOutput("ld_v",     32'(bus.ld_v),     32'(mLdV));
        checkOutput("ld_data",  bus.ld_data,       mLdData);
        checkOutput("shift_v",  32'(bus.shift_v),  32'(mBurst > 0));
        checkOutput("round",    32'(bus.round),    32'(eRound));
        checkOutput("busy",     32'(bus.busy),     32'(mActive));
        checkOutput("done",     32'(bus.done),     32'(mDone));
        if (bus.ld_v === 1'b1) ldCnt++;
        if (bus.done === 1'b1) doneCnt++;
        if (bus.shift_v === 1'b1) begin
            shCnt++;
            runLen++;
        end else begin
            if (runLen != 0 && runLen != RG) burstBad++;
            runLen = 0;
        end
    endtask

    task automatic clearCounts(input string name);
        scen = name;
        ldCnt = 0; shCnt = 0; doneCnt = 0; runLen = 0; burstBad = 0;
    endtask

    task automatic pulseStart();
        dStart = 1;
        applyStimulus();
        dStart = 0;
    endtask

    initial begin
        int n, waitCyc;
        passCnt = 0; totalCnt = 0;
        dRst = 1; dStart = 0; dAbort = 0; dValid = 0; dPe = 0; dData = '0;
        mWords = 0; mShifts = 0; mBurst = 0; mActive = 0; mDone = 0; mLdV = 0; mLdData = '0;

        clearCounts("reset");
        applyStimulus();
        applyStimulus();
        dRst = 0;
        applyStimulus();

        // Scenario 1: continuous stream 1..16, PE array always ready.
        clearCounts("t1");
        dValid = 1; dPe = 1; dData = 32'd1;
        pulseStart();
        n = 0;
        while (mActive && n < 200) begin
            dData = 32'(mWords + 1);
            applyStimulus();
            n++;
        end
        checkOutput("end_idle", 32'(bus.busy), 32'd0);
        checkOutput("ld_count", 32'(ldCnt), 32'(NW));
        checkOutput("shift_count", 32'(shCnt), 32'(NS));
        checkOutput("done_count", 32'(doneCnt), 32'd1);
        checkOutput("burst_len", 32'(burstBad), 32'd0);
        applyStimulus();

        // Scenario 2: in_valid toggles during load, then stays high.
        clearCounts("t2");
        pulseStart();
        n = 0;
        while (mActive && n < 200) begin
            dValid = (mWords >= NW) ? 1'b1 : bit'(n % 2);
            dData  = $urandom;
            applyStimulus();
            n++;
        end
        checkOutput("end_idle", 32'(bus.busy), 32'd0);
        checkOutput("ld_count", 32'(ldCnt), 32'(NW));
        checkOutput("done_count", 32'(doneCnt), 32'd1);

        // Scenario 3: PE array stalls after load and between rounds, drops mid-burst.
        clearCounts("t3");
        dValid = 1; dPe = 0;
        pulseStart();
        n = 0; waitCyc = 0;
        while (mActive && n < 400) begin
            if (mWords == NW && mBurst == 0) waitCyc++;
            if (mBurst > 0) dPe = (mBurst > 2);
            else dPe = (waitCyc > 10) && ($urandom_range(0, 2) == 0);
            dData = $urandom;
            applyStimulus();
            n++;
        end
        checkOutput("end_idle", 32'(bus.busy), 32'd0);
        checkOutput("shift_count", 32'(shCnt), 32'(NS));
        checkOutput("burst_len", 32'(burstBad), 32'd0);
        checkOutput("done_count", 32'(doneCnt), 32'd1);

        // Scenario 4: abort on third shift cycle of round 0, then clean restart.
        clearCounts("t4");
        dValid = 1; dPe = 1;
        pulseStart();
        n = 0;
        while (mActive && n < 200) begin
            dAbort = (mBurst > 0) && (mShifts == 2);
            dData  = $urandom;
            applyStimulus();
            dAbort = 0;
            n++;
        end
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_shift", 32'(bus.shift_v), 32'd0);
        checkOutput("abort_done", 32'(doneCnt), 32'd0);
        clearCounts("t4b");
        pulseStart();
        checkOutput("restart_round", 32'(bus.round), 32'd0);
        n = 0;
        while (mActive && n < 200) begin
            dData = 32'(mWords + 1);
            applyStimulus();
            n++;
        end
        checkOutput("ld_count", 32'(ldCnt), 32'(NW));
        checkOutput("done_count", 32'(doneCnt), 32'd1);

        // Scenario 5: reset mid-load, then start pulses while busy and in the DONE cycle.
        clearCounts("t5");
        pulseStart();
        n = 0;
        while (mWords < 7 && n < 100) begin
            dData = $urandom;
            applyStimulus();
            n++;
        end
        dRst = 1;
        applyStimulus();
        dRst = 0;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ldv", 32'(bus.ld_v), 32'd0);
        clearCounts("t5b");
        pulseStart();
        n = 0;
        while (mActive && n < 200) begin
            dStart = mDone || ($urandom_range(0, 3) == 0);
            dData  = $urandom;
            applyStimulus();
            n++;
        end
        dStart = 0;
        applyStimulus();
        checkOutput("no_restart", 32'(bus.busy), 32'd0);
        checkOutput("done_count", 32'(doneCnt), 32'd1);

        // Random traffic with occasional aborts and starts, checked cycle by cycle.
        clearCounts("rand");
        for (int i = 0; i < 600; i++) begin
            dStart = ($urandom_range(0, 7) == 0);
            dAbort = ($urandom_range(0, 79) == 0);
            dValid = ($urandom_range(0, 3) != 0);
            dPe    = ($urandom_range(0, 2) == 0);
            dData  = $urandom;
            applyStimulus();
        end
        dStart = 0; dAbort = 0;

        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
